// File: rtl/fc1_ctrl.sv
// FC1 sequencer: loads weights/biases from ROM once, then streams packed feature beats per frame.
// Optional wait-state watchdog with o_timeout port: define FC1_CTRL_TIMEOUT_EN.
module fc1_ctrl #(
  parameter int INPUT_NUM  = 48,
  parameter int OUTPUT_NUM = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [9:0]  w_rd_addr,
  input  logic [7:0]  w_rd_data,
  output logic        weight_valid,
  output logic [7:0]  filter,
  input  logic        weight_done,
  output logic [4:0]  f_rd_addr,
  input  logic [47:0] f_rd_data,
  output logic        fc_valid,
  output logic [15:0] data_in_1,
  output logic [15:0] data_in_2,
  output logic [15:0] data_in_3,
  input  logic        fc_o_valid,
  output logic        o_busy,
  output logic        o_done
`ifdef FC1_CTRL_TIMEOUT_EN
  , output logic      o_timeout
`endif
);

  localparam int NW = INPUT_NUM * OUTPUT_NUM + OUTPUT_NUM;
  localparam int NB = INPUT_NUM / 3;
  localparam logic [9:0] W_LAST = 10'(NW - 1);
  localparam logic [4:0] F_LAST = 5'(NB - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_WD, FEED, WAIT_RES, DONE} state_t;

  state_t      state_q;
  logic        loaded_q;
  logic [9:0]  w_addr_q;
  logic [4:0]  f_addr_q;
  logic        wv_q, fv_q, done_q;
`ifdef FC1_CTRL_TIMEOUT_EN
  logic [7:0]  tmo_q;
  logic        tmo_pulse_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      loaded_q    <= 1'b0;
      w_addr_q    <= '0;
      f_addr_q    <= '0;
      wv_q        <= 1'b0;
      fv_q        <= 1'b0;
      done_q      <= 1'b0;
`ifdef FC1_CTRL_TIMEOUT_EN
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
`endif
    end else begin
      // Strobes trail the address issue by one cycle to match the 1-cycle read ports.
      wv_q   <= (state_q == LOAD_W);
      fv_q   <= (state_q == FEED);
      done_q <= 1'b0;
`ifdef FC1_CTRL_TIMEOUT_EN
      tmo_pulse_q <= 1'b0;
      tmo_q <= (state_q == WAIT_WD || state_q == WAIT_RES) ? tmo_q + 8'd1 : 8'd0;
`endif
      case (state_q)
        IDLE:
          if (i_start) state_q <= loaded_q ? FEED : LOAD_W;
        LOAD_W:
          if (w_addr_q == W_LAST) begin
            w_addr_q <= '0;
            state_q  <= WAIT_WD;
          end else begin
            w_addr_q <= w_addr_q + 10'd1;
          end
        WAIT_WD:
          if (weight_done) begin
            loaded_q <= 1'b1;
            state_q  <= FEED;
          end
`ifdef FC1_CTRL_TIMEOUT_EN
          else if (tmo_q == 8'd254) begin
            state_q     <= IDLE;
            tmo_pulse_q <= 1'b1;
          end
`endif
        FEED:
          if (f_addr_q == F_LAST) begin
            f_addr_q <= '0;
            state_q  <= WAIT_RES;
          end else begin
            f_addr_q <= f_addr_q + 5'd1;
          end
        WAIT_RES:
          if (fc_o_valid) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
`ifdef FC1_CTRL_TIMEOUT_EN
          else if (tmo_q == 8'd254) begin
            state_q     <= IDLE;
            tmo_pulse_q <= 1'b1;
          end
`endif
        DONE:
          state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

  // Read data is forwarded straight from the 1-cycle-latency ports so it lines up with its strobe.
  assign w_rd_addr    = w_addr_q;
  assign f_rd_addr    = f_addr_q;
  assign weight_valid = wv_q;
  assign fc_valid     = fv_q;
  assign filter       = wv_q ? w_rd_data : 8'd0;
  assign data_in_1    = fv_q ? f_rd_data[15:0]  : 16'd0;
  assign data_in_2    = fv_q ? f_rd_data[31:16] : 16'd0;
  assign data_in_3    = fv_q ? f_rd_data[47:32] : 16'd0;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
`ifdef FC1_CTRL_TIMEOUT_EN
  assign o_timeout    = tmo_pulse_q;
`endif

endmodule

// File: tb/tb_fc1_ctrl.sv
// Directed bench for fc1_ctrl: weight load, feature streaming, start filtering, reset abort.
module tb_fc1_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst, i_start, weight_valid, weight_done, fc_valid, fc_o_valid, o_busy, o_done;
  logic [9:0]  w_rd_addr;
  logic [7:0]  w_rd_data, filter;
  logic [4:0]  f_rd_addr;
  logic [47:0] f_rd_data;
  logic [15:0] data_in_1, data_in_2, data_in_3;
`ifdef FC1_CTRL_TIMEOUT_EN
  logic        o_timeout;
`endif

  logic [47:0] fmem [0:31];
  int errs = 0, checks = 0;
  int wv_total = 0, done_total = 0, ovl = 0;
  int snap, dsnap;

  fc1_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .weight_valid(weight_valid), .filter(filter), .weight_done(weight_done),
    .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data), .fc_valid(fc_valid),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .fc_o_valid(fc_o_valid), .o_busy(o_busy), .o_done(o_done)
`ifdef FC1_CTRL_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  always #5 i_clk = ~i_clk;

  // 1-cycle-latency ROM (data = address low byte) and feature buffer.
  always @(posedge i_clk) begin
    w_rd_data <= w_rd_addr[7:0];
    f_rd_data <= fmem[f_rd_addr];
  end

  always @(posedge i_clk) begin
    if (weight_valid) wv_total <= wv_total + 1;
    if (o_done) done_total <= done_total + 1;
    if (weight_valid && fc_valid) ovl <= ovl + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // Start a frame that must load weights; returns in the first FEED cycle.
  task automatic load(input string tag, input int pulse_at);
    int cyc, n, bad;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk({tag, "_addr0"}, longint'(w_rd_addr), 0);
    chk({tag, "_busy"}, longint'(o_busy), 1);
    chk({tag, "_wv_not_yet"}, longint'(weight_valid), 0);
    cyc = 0;
    while (!weight_valid && cyc < 8) begin step(); cyc++; end
    chk({tag, "_wv_lat"}, cyc, 1);
    n = 0; bad = 0;
    while (weight_valid && n < 1000) begin
      if (filter !== 8'(n)) bad++;
      if (pulse_at >= 0) i_start = (n == pulse_at);
      step();
      n++;
    end
    i_start = 1'b0;
    chk({tag, "_wv_count"}, n, 784);
    chk({tag, "_filter_bad"}, bad, 0);
    step();
    chk({tag, "_waitwd_hold"}, longint'({o_busy, fc_valid, weight_valid}), 4);
    weight_done = 1'b1;
    step();
    weight_done = 1'b0;
    chk({tag, "_feed_addr0"}, longint'(f_rd_addr), 0);
  endtask

  // Collect the feature beats; returns the cycle after the last strobe.
  task automatic feed(input string tag, input int exp_lat, input int pulse_at);
    int cyc, k, bad_d, bad_a;
    logic [4:0] last_fa;
    cyc = 0;
    last_fa = f_rd_addr;
    while (!fc_valid && cyc < 8) begin last_fa = f_rd_addr; step(); cyc++; end
    chk({tag, "_fv_lat"}, cyc, exp_lat);
    k = 0; bad_d = 0; bad_a = 0;
    while (fc_valid && k < 32) begin
      if (k == 0) chk({tag, "_beat0"}, longint'({data_in_3, data_in_2, data_in_1}), 48'h0003_0002_0001);
      if ({data_in_3, data_in_2, data_in_1} !== fmem[k]) bad_d++;
      if (last_fa !== k[4:0]) bad_a++;
      if (pulse_at >= 0) begin
        i_start    = (k == pulse_at);
        fc_o_valid = (k == pulse_at);
      end
      last_fa = f_rd_addr;
      step();
      k++;
    end
    if (pulse_at >= 0) begin i_start = 1'b0; fc_o_valid = 1'b0; end
    chk({tag, "_fv_count"}, k, 16);
    chk({tag, "_data_bad"}, bad_d, 0);
    chk({tag, "_addr_order_bad"}, bad_a, 0);
  endtask

  task automatic finish_frame(input string tag);
    repeat (3) step();
    chk({tag, "_waitres_hold"}, longint'({o_busy, o_done}), 2);
    fc_o_valid = 1'b1;
    step();
    fc_o_valid = 1'b0;
    chk({tag, "_done_pulse"}, longint'({o_busy, o_done}), 3);
    step();
    chk({tag, "_idle"}, longint'({o_busy, o_done}), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) fmem[i] = {16'(3*i+3), 16'(3*i+2), 16'(3*i+1)};
    i_rst = 1'b1; i_start = 1'b0; weight_done = 1'b0; fc_o_valid = 1'b0;
    repeat (3) step();
    chk("rst_addrs", longint'({w_rd_addr, f_rd_addr}), 0);
    chk("rst_strobes", longint'({weight_valid, fc_valid, o_busy, o_done}), 0);
    chk("rst_data", longint'({filter, data_in_1, data_in_2, data_in_3}), 0);
    i_rst = 1'b0;
    step();
    chk("idle_after_rst", longint'(o_busy), 0);

    // Frame 1: full load, then features
    dsnap = done_total;
    load("f1", -1);
    feed("f1", 1, -1);
    finish_frame("f1");

    // Frame 2: weights already loaded
    snap = wv_total;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("f2_wv_none", longint'(weight_valid), 0);
    feed("f2", 1, -1);
    finish_frame("f2");
    chk("f2_no_reload", wv_total - snap, 0);
    chk("f12_dones", done_total - dsnap, 2);

    // Reset mid-load at address 400
    i_rst = 1'b1; step(); i_rst = 1'b0; step();
    i_start = 1'b1; step(); i_start = 1'b0;
    n = 0;
    while (w_rd_addr != 10'd400 && n < 600) begin step(); n++; end
    chk("rst_reach400", longint'(w_rd_addr), 400);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_outputs", longint'({w_rd_addr, weight_valid, filter, o_busy, fc_valid}), 0);
    snap = wv_total;
    repeat (3) step();
    i_rst = 1'b0;
    repeat (3) step();
    chk("rst_no_strobes", wv_total - snap, 0);
    chk("rst_idle", longint'(o_busy), 0);

    // Frame 3: reload from 0, with stray starts and an early fc_o_valid
    dsnap = done_total;
    load("f3", 100);
    feed("f3", 1, 5);
    finish_frame("f3");
    repeat (2) step();
    chk("f3_no_queue", longint'(o_busy), 0);
    chk("f3_one_done", done_total - dsnap, 1);

    // Held start: new frame begins right after the IDLE cycle following DONE
    i_start = 1'b1;
    step();
    feed("f4", 1, -1);
    finish_frame("f4");
    step();
    chk("held_restart", longint'({o_busy, f_rd_addr}), 32);
    i_start = 1'b0;
    feed("f5", 1, -1);
    finish_frame("f5");

`ifdef FC1_CTRL_TIMEOUT_EN
    dsnap = done_total;
    i_start = 1'b1; step(); i_start = 1'b0;
    feed("to", 1, -1);
    n = 0;
    while (!o_timeout && n < 400) begin step(); n++; end
    chk("to_latency", n, 254);
    chk("to_idle", longint'({o_busy, o_done}), 0);
    step();
    chk("to_pulse_width", longint'(o_timeout), 0);
    chk("to_no_done", done_total - dsnap, 0);
`endif

    chk("no_overlap", ovl, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
